// File: rtl/jk_drive_ctrl.sv
// jk_drive_ctrl: turns a stream of target Q bits into J/K commands for an
// external JK flip-flop and checks that flip-flop's Q against an internal
// model of what it should hold, counting any disagreement.
//
// Handshake: d_in is transferred on a rising edge where d_valid && d_ready.
// d_ready depends only on internal state, never on d_valid, and a producer
// holds d_in/d_valid until the transfer happens.
module jk_drive_ctrl #(
    parameter int DEPTH      = 4,
    parameter bit USE_TOGGLE = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   d_in,
    input  logic                   d_valid,
    output logic                   d_ready,
    input  logic                   issue_en,
    input  logic                   q_fb,
    output logic                   J,
    output logic                   K,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   mismatch,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [1:0]             dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic           mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic           push, pop, head;
    logic           q_model, q_nxt;
    logic           j_nxt, k_nxt;
    logic           chk_v_nxt, chk_e_nxt;
    logic           chk1_v, chk1_e, chk2_v, chk2_e;
    logic           bad;

    assign head      = mem[rd_ptr];
    assign d_ready   = (state != S_INIT) && (level < LW'(DEPTH));
    assign push      = d_valid && d_ready;
    assign pop       = (state == S_RUN) && issue_en && (level != '0);
    assign busy      = (state != S_RUN) || (level != '0) || chk1_v || chk2_v;
    assign bad       = chk2_v && (q_fb != chk2_e);
    assign dbg_state = state;

    // Sequencer: clear the external flop, let it settle, then issue from the FIFO.
    always_comb begin
        state_nxt = state;
        j_nxt     = 1'b0;
        k_nxt     = 1'b0;
        chk_v_nxt = 1'b0;
        chk_e_nxt = 1'b0;
        q_nxt     = q_model;
        case (state)
            S_INIT: begin
                k_nxt     = 1'b1;
                chk_v_nxt = 1'b1;
                chk_e_nxt = 1'b0;
                q_nxt     = 1'b0;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (pop) begin
                    chk_v_nxt = 1'b1;
                    chk_e_nxt = head;
                    q_nxt     = head;
                    // Only a change of Q needs a command; toggle mode uses J=K=1.
                    if (head != q_model) begin
                        j_nxt = head ? 1'b1 : USE_TOGGLE;
                        k_nxt = head ? USE_TOGGLE : 1'b1;
                    end
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= S_INIT;
        else        state <= state_nxt;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave level alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // FIFO storage; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= d_in;
    end

    // Command outputs, Q model, two-stage check pipeline and error counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            J        <= 1'b0;
            K        <= 1'b0;
            q_model  <= 1'b0;
            chk1_v   <= 1'b0;
            chk1_e   <= 1'b0;
            chk2_v   <= 1'b0;
            chk2_e   <= 1'b0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            J        <= j_nxt;
            K        <= k_nxt;
            q_model  <= q_nxt;
            chk1_v   <= chk_v_nxt;
            chk1_e   <= chk_e_nxt;
            chk2_v   <= chk1_v;
            chk2_e   <= chk1_e;
            mismatch <= bad;
            if (bad && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// Bench for jk_drive_ctrl: two instances (set/reset encoding with an 8-bit
// counter, toggle encoding with a 2-bit counter) share one stimulus stream,
// each drives its own JK flip-flop, and a queue-based model predicts outputs.
module tb_jk_drive_ctrl;

    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;
    logic d_in = 1'b0, d_valid = 1'b0, issue_en = 1'b0, force_zero = 1'b0;

    logic       j0, k0, rdy0, busy0, mis0;
    logic [2:0] lvl0;
    logic [7:0] err0;
    logic [1:0] st0;
    logic       j1, k1, rdy1, busy1, mis1;
    logic [2:0] lvl1;
    logic [1:0] err1;
    logic [1:0] st1;

    // External JK flip-flops (start at 1 so the INIT clear is observable).
    logic q_ext0 = 1'b1, q_ext1 = 1'b1;
    logic q_fb0, q_fb1;
    assign q_fb0 = force_zero ? 1'b0 : q_ext0;
    assign q_fb1 = force_zero ? 1'b0 : q_ext1;

    always @(posedge clk) begin
        case ({j0, k0})
            2'b01:   q_ext0 <= 1'b0;
            2'b10:   q_ext0 <= 1'b1;
            2'b11:   q_ext0 <= ~q_ext0;
            default: q_ext0 <= q_ext0;
        endcase
        case ({j1, k1})
            2'b01:   q_ext1 <= 1'b0;
            2'b10:   q_ext1 <= 1'b1;
            2'b11:   q_ext1 <= ~q_ext1;
            default: q_ext1 <= q_ext1;
        endcase
    end

    jk_drive_ctrl #(.DEPTH(DEPTH), .USE_TOGGLE(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid), .d_ready(rdy0),
        .issue_en(issue_en), .q_fb(q_fb0), .J(j0), .K(k0), .level(lvl0),
        .busy(busy0), .mismatch(mis0), .err_cnt(err0), .dbg_state(st0)
    );

    jk_drive_ctrl #(.DEPTH(DEPTH), .USE_TOGGLE(1'b1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid), .d_ready(rdy1),
        .issue_en(issue_en), .q_fb(q_fb1), .J(j1), .K(k1), .level(lvl1),
        .busy(busy1), .mismatch(mis1), .err_cnt(err1), .dbg_state(st1)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        int unsigned due;
        logic        exp;
    } chk_t;

    logic [0:0]  exp_q[$];      // bits waiting in the FIFO
    chk_t        chk_q[$];      // Q checks scheduled for a given edge
    int unsigned edge_n = 0;
    int          m_since = 0;   // edges since reset release: 0 init, 1 settle, 2+ run
    logic        m_q = 1'b0;
    logic        m_j[2] = '{1'b0, 1'b0};
    logic        m_k[2] = '{1'b0, 1'b0};
    logic        m_ext[2] = '{1'b1, 1'b1};
    logic        m_mis[2] = '{1'b0, 1'b0};
    int          m_err[2] = '{0, 0};
    int          m_errmax[2] = '{255, 3};
    logic        m_tog[2] = '{1'b0, 1'b1};

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void model_edge();
        logic qfb[2];
        logic has_chk, chk_exp, pre_rdy, t;
        chk_t c;
        for (int i = 0; i < 2; i++) qfb[i] = force_zero ? 1'b0 : m_ext[i];
        for (int i = 0; i < 2; i++) begin
            case ({m_j[i], m_k[i]})
                2'b01:   m_ext[i] = 1'b0;
                2'b10:   m_ext[i] = 1'b1;
                2'b11:   m_ext[i] = ~m_ext[i];
                default: m_ext[i] = m_ext[i];
            endcase
        end
        if (!reset) begin
            exp_q.delete();
            chk_q.delete();
            m_since = 0;
            m_q = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_j[i] = 1'b0; m_k[i] = 1'b0; m_mis[i] = 1'b0; m_err[i] = 0;
            end
        end else begin
            pre_rdy = (m_since != 0) && (exp_q.size() < DEPTH);
            has_chk = (chk_q.size() > 0) && (chk_q[0].due == edge_n);
            chk_exp = 1'b0;
            if (has_chk) begin
                chk_exp = chk_q[0].exp;
                void'(chk_q.pop_front());
            end
            for (int i = 0; i < 2; i++) begin
                m_mis[i] = has_chk && (qfb[i] != chk_exp);
                if (m_mis[i] && m_err[i] < m_errmax[i]) m_err[i]++;
                m_j[i] = 1'b0;
                m_k[i] = 1'b0;
            end
            if (m_since == 0) begin
                for (int i = 0; i < 2; i++) m_k[i] = 1'b1;
                m_q = 1'b0;
                c.due = edge_n + 2; c.exp = 1'b0;
                chk_q.push_back(c);
            end else if (m_since >= 2 && issue_en && exp_q.size() > 0) begin
                t = exp_q.pop_front();
                for (int i = 0; i < 2; i++) begin
                    if (t != m_q) begin
                        m_j[i] = t ? 1'b1 : m_tog[i];
                        m_k[i] = t ? m_tog[i] : 1'b1;
                    end
                end
                m_q = t;
                c.due = edge_n + 2; c.exp = t;
                chk_q.push_back(c);
            end
            if (d_valid && pre_rdy) exp_q.push_back(d_in);
            if (m_since < 2) m_since++;
        end
        edge_n++;
    endfunction

    function automatic logic [27:0] obs_vec();
        return {j0, k0, j1, k1, lvl0, lvl1, rdy0, rdy1, mis0, mis1, busy0, busy1, err0, err1};
    endfunction

    function automatic logic [27:0] exp_vec();
        logic [2:0] l;
        logic r, b;
        l = 3'(exp_q.size());
        r = (m_since != 0) && (exp_q.size() < DEPTH);
        b = (m_since < 2) || (exp_q.size() != 0) || (chk_q.size() != 0);
        return {m_j[0], m_k[0], m_j[1], m_k[1], l, l, r, r, m_mis[0], m_mis[1], b, b,
                8'(m_err[0]), 2'(m_err[1])};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic rst_n, input logic dv, input logic din, input logic ie);
        @(negedge clk);
        reset    = rst_n;
        d_valid  = dv;
        d_in     = din;
        issue_en = ie;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if ({j0, k0, lvl0, rdy0, mis0, err0, busy0} !== {2'b00, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_vals dut0 got=%h exp=%h", {j0, k0, lvl0, rdy0, mis0, err0, busy0},
                         {2'b00, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1});
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({j0, k0, j1, k1, rdy0} !== 5'b01011) begin
            n_fail++;
            $display("FAIL init_clear got=%b exp=%b", {j0, k0, j1, k1, rdy0}, 5'b01011);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({j0, k0, j1, k1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL settle_jk got=%b exp=%b", {j0, k0, j1, k1}, 4'b0000);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({busy0, busy1, err0, err1} !== 12'd0) begin
            n_fail++;
            $display("FAIL idle_after_init got=%h exp=0", {busy0, busy1, err0, err1});
        end
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_stream();
        logic       bits[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0] jk0_exp[5] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        logic [1:0] jk1_exp[5] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11};
        logic [1:0] jk0_got[8];
        logic [1:0] jk1_got[8];
        logic       busy_got[8];
        for (int c = 0; c < 8; c++) begin
            if (c < 5) drive(1'b1, 1'b1, bits[c], 1'b1);
            else       drive(1'b1, 1'b0, 1'b0, 1'b1);
            jk0_got[c]  = {j0, k0};
            jk1_got[c]  = {j1, k1};
            busy_got[c] = busy0;
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stream_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (jk0_got[c+1] !== jk0_exp[c] || jk1_got[c+1] !== jk1_exp[c]) begin
                n_fail++;
                $display("FAIL stream_jk c=%0d got=%b/%b exp=%b/%b", c, jk0_got[c+1], jk1_got[c+1],
                         jk0_exp[c], jk1_exp[c]);
            end
        end
        n_tests++;
        if ({busy_got[6], busy_got[7]} !== 2'b10) begin
            n_fail++;
            $display("FAIL stream_busy_fall got=%b exp=%b", {busy_got[6], busy_got[7]}, 2'b10);
        end
    endtask

    task automatic test_full();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL full_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (c >= 3) begin
                n_tests++;
                if ({lvl0, lvl1, rdy0, rdy1} !== {3'd4, 3'd4, 2'b00}) begin
                    n_fail++;
                    $display("FAIL full_level c=%0d got=%b exp=%b", c, {lvl0, lvl1, rdy0, rdy1},
                             {3'd4, 3'd4, 2'b00});
                end
            end
        end
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL drain_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
        n_tests++;
        if ({lvl0, rdy0, busy0} !== {3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL drain_empty got=%b exp=%b", {lvl0, rdy0, busy0}, {3'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_saturate();
        logic       bits[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] sat_exp[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        int         pulses = 0;
        force_zero = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c < 5) drive(1'b1, 1'b1, bits[c], 1'b1);
            else       drive(1'b1, 1'b0, 1'b0, 1'b1);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL sat_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (mis1 === 1'b1) begin
                if (pulses < 4) begin
                    n_tests++;
                    if (err1 !== sat_exp[pulses]) begin
                        n_fail++;
                        $display("FAIL sat_err pulse=%0d got=%0d exp=%0d", pulses, err1, sat_exp[pulses]);
                    end
                end
                pulses++;
            end
        end
        force_zero = 1'b0;
        n_tests++;
        if (pulses !== 4 || err0 !== 8'd4 || err1 !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_total got=%0d/%0d/%0d exp=4/4/3", pulses, err0, err1);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (lvl0 !== 3'd3 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre got=%0d/%b exp=3/1", lvl0, busy0);
        end
        force_zero = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({lvl0, lvl1, j0, k0, j1, k1, err0, err1, mis0, mis1} !== 22'd0) begin
            n_fail++;
            $display("FAIL mid_reset got=%h exp=0", {lvl0, lvl1, j0, k0, j1, k1, err0, err1, mis0, mis1});
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL mid_replay c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (c == 0) begin
                n_tests++;
                if ({j0, k0, j1, k1} !== 4'b0101) begin
                    n_fail++;
                    $display("FAIL mid_init_jk got=%b exp=%b", {j0, k0, j1, k1}, 4'b0101);
                end
            end
            n_tests++;
            if ({mis0, mis1} !== 2'b00) begin
                n_fail++;
                $display("FAIL mid_no_mismatch c=%0d got=%b exp=00", c, {mis0, mis1});
            end
        end
        force_zero = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) force_zero = ($urandom_range(0, 3) == 0);
            drive(1'($urandom_range(0, 79) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
        force_zero = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_stream();
        test_full();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_drive_ctrl.md
Name: jk_drive_ctrl

Overview:
- Drive-side controller for the JK flip-flop built from a D flip-flop, acting as the inverse (D-to-JK) conversion.
- Accepts a stream of target Q bits on a valid/ready interface and buffers them in a small FIFO.
- For each target bit it issues the J/K command that makes an external JK flip-flop follow the stream.
- Checks the external flip-flop's Q against an internal model and counts mismatches, so it serves as both stimulus generator and self-checking monitor in conversion benches.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- USE_TOGGLE, 0: 1 = a change of Q is commanded with J=K=1 (toggle); 0 = commanded with set (J=1,K=0) or reset (J=0,K=1).
- CNT_W, 8: width of the mismatch counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 at posedge resets).
- d_in  in  1  target Q value.
- d_valid  in  1  d_in valid.
- d_ready  out  1  FIFO can accept.
- issue_en  in  1  1 = FIFO may pop; 0 = stall issue.
- q_fb  in  1  Q output of the external JK flip-flop.
- J  out  1  registered J command.
- K  out  1  registered K command.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  work outstanding.
- mismatch  out  1  one-cycle pulse on a Q check failure.
- err_cnt  out  CNT_W  saturating mismatch count.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low. Ports are named clk and reset.
- Reset value of every output: J=0, K=0, level=0, d_ready=0, mismatch=0, err_cnt=0, busy=1.
- Reset also clears q_model=0, flushes the FIFO and the check pipeline, and sets state=INIT.
- States: INIT -> SETTLE -> RUN; no other transitions except reset.
  - INIT (1 cycle after reset release): registers J=0, K=1 to clear the external flip-flop. Enters a check with expected 0. Goes to SETTLE.
  - SETTLE (1 cycle): J=0, K=0. Goes to RUN.
  - RUN: at each posedge with issue_en=1 and level>0, pops the head bit t, registers J/K, sets q_model<=t and enters a check with expected t. Otherwise J=K=0 and no check is entered.
- J/K encoding:
  - t==q_model: J=0, K=0.
  - t=1, q_model=0: J=1, K=USE_TOGGLE.
  - t=0, q_model=1: J=USE_TOGGLE, K=1.
- d_ready = (state != INIT) && (level < DEPTH). A push occurs on d_valid && d_ready.
- Push and pop on the same edge: level unchanged, data order preserved. A push into an empty FIFO pops no earlier than the next edge.
- Latency: accept at edge a -> J/K valid after edge a+1 -> external flip-flop updates at a+2 -> q_fb compared at edge a+3.
- Check pipeline is 2 stages of {valid, expected}. At compare: if q_fb != expected, mismatch=1 for one cycle and err_cnt increments, saturating at 2^CNT_W-1. Otherwise mismatch=0.
- busy = (state != RUN) || (level != 0) || (any check stage valid).
- When the FIFO is full, d_valid is ignored and the FIFO contents are unchanged.
- Reset mid-operation: all in-flight entries and checks are discarded, with no mismatch reported for them. err_cnt clears and the INIT sequence replays after release.

Test Plan:
1. Reset low 3 cycles, then high -> J/K = 0/1 for 1 cycle, then 0/0. d_ready=1 from the SETTLE cycle. After 3 cycles busy=0 with a model JK flip-flop attached, and err_cnt=0.
2. USE_TOGGLE=0, issue_en=1, push 1,1,0,0,1 back-to-back -> J/K = 10,00,01,00,10 on consecutive cycles. q_fb follows 1,1,0,0,1, mismatch is never asserted, and busy falls 3 cycles after the last accept.
3. USE_TOGGLE=1, same stream -> J/K = 11,00,11,00,11. err_cnt=0.
4. DEPTH=4, issue_en=0, push 5 bits -> 4 accepted, level=4, d_ready=0 and the 5th is held. With issue_en=1, 4 pops occur in order, level reaches 0 and d_ready returns to 1.
5. CNT_W=2, q_fb forced 0, push 1,0,1,1,1 -> mismatch pulses for each expected-1 check. err_cnt goes 1,2,3 and stays 3 (saturated).
6. level=3 with checks in flight, reset low 1 cycle -> level=0, J/K=00, err_cnt=0, and no mismatch pulse. After release the INIT (J/K=01) sequence repeats.
